// File: rtl/pipe_csel_adder_pkg.sv
// pipe_csel_adder_pkg: default sizes and the stage-1 carry-select block record.
package pipe_csel_adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK = 4;
  typedef struct packed {
    logic [DEF_BLK-1:0] sum0;
    logic [DEF_BLK-1:0] sum1;
    logic c0;
    logic c1;
  } blk_rec_t;
endpackage

// File: rtl/pipe_csel_adder_csel_block.sv
// csel_block: W-bit ripple adder producing sum and carry-out for a given carry-in.
module csel_block
  import pipe_csel_adder_pkg::*;
#(
  parameter int W = DEF_BLK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic c;
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/pipe_csel_adder.sv
// pipe_csel_adder: two-stage pipelined carry-select add/sub with valid/ready handshake.
// Define PIPE_CSEL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_csel_adder
  import pipe_csel_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
`ifdef PIPE_CSEL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int NB = WIDTH / BLK;
  if (WIDTH % BLK != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of BLK");
  end
  // stage-1 record width is fixed by the package typedef
  if (BLK != DEF_BLK) begin : g_bad_blk
    $error("BLK must equal DEF_BLK");
  end
  logic [WIDTH-1:0] bx, y_d;
  logic ci, v1, v2, ld2, c0_d, c0_q, co_d;
  logic [BLK-1:0] s0_d, s0_q;
  blk_rec_t cand [NB];
  blk_rec_t r1 [NB];
  assign bx = sub ? ~b : b;
  assign ci = sub | cin;
  for (genvar i = 0; i < NB; i++) begin : g_blk
    csel_block #(.W(BLK)) u_c0 (.a(a[i*BLK+:BLK]), .b(bx[i*BLK+:BLK]), .ci(1'b0), .s(cand[i].sum0), .co(cand[i].c0));
    csel_block #(.W(BLK)) u_c1 (.a(a[i*BLK+:BLK]), .b(bx[i*BLK+:BLK]), .ci(1'b1), .s(cand[i].sum1), .co(cand[i].c1));
  end
  assign s0_d = ci ? cand[0].sum1 : cand[0].sum0;
  assign c0_d = ci ? cand[0].c1 : cand[0].c0;
  assign in_ready = !v1 || !v2 || out_ready;
  assign ld2 = v1 && (!v2 || out_ready);
  assign out_valid = v2;
`ifdef PIPE_CSEL_ADDER_OVF_EN
  logic am_q, bm_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q <= 1'b0;
      bm_q <= 1'b0;
    end else if (in_ready) begin
      am_q <= a[WIDTH-1];
      bm_q <= bx[WIDTH-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (ld2) ovf <= (am_q == bm_q) && (y_d[WIDTH-1] != am_q);
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s0_q <= '0;
      c0_q <= 1'b0;
      r1 <= '{default: '0};
    end else if (in_ready) begin
      v1 <= in_valid;
      s0_q <= s0_d;
      c0_q <= c0_d;
      r1 <= cand;
    end
  end
  // upper blocks pick their precomputed candidate from the rippled block carry
  always_comb begin
    y_d = '0;
    co_d = c0_q;
    y_d[BLK-1:0] = s0_q;
    for (int i = 1; i < NB; i++) begin
      y_d[i*BLK+:BLK] = co_d ? r1[i].sum1 : r1[i].sum0;
      co_d = co_d ? r1[i].c1 : r1[i].c0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      y <= '0;
      cout <= 1'b0;
    end else begin
      v2 <= ld2 || (v2 && !out_ready);
      if (ld2) begin
        y <= y_d;
        cout <= co_d;
      end
    end
  end
endmodule

// File: tb/tb_pipe_csel_adder.sv
// tb_pipe_csel_adder: directed vector table plus backpressure, reset and random streaming checks.
module tb_pipe_csel_adder;
  logic clk = 0, rst_n = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 0;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid, cout;
  logic [15:0] y;
`ifdef PIPE_CSEL_ADDER_OVF_EN
  logic ovf;
`endif
  int checks = 0, failures = 0, beats = 0, pops = 0;
  always #5 clk = ~clk;

  pipe_csel_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .y(y),
`ifdef PIPE_CSEL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  typedef struct {logic [15:0] a, b; logic cin, sub; logic [15:0] y; logic co, ov;} vec_t;
  typedef struct {logic [15:0] y; logic co, ov;} res_t;
  vec_t vt[11];
  res_t q[$];
  logic hold = 0, hc;
  logic [15:0] hy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is);
    logic [15:0] bb;
    logic [16:0] s;
    res_t r;
    bb = is ? ~ib : ib;
    s = {1'b0, ia} + {1'b0, bb} + 17'(is | ic);
    r.y = s[15:0];
    r.co = s[16];
    r.ov = (ia[15] == bb[15]) && (s[15] != ia[15]);
    return r;
  endfunction

  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic is, input logic ordy, output logic acc);
    res_t e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
    #1;
    if (hold) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_y", 32'(y), 32'(hy));
      chk("stall_cout", 32'(cout), 32'(hc));
    end
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      pops++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_beat actual=%0h expected=none", y);
      end else begin
        e = q.pop_front();
        chk("stream_y", 32'(y), 32'(e.y));
        chk("stream_cout", 32'(cout), 32'(e.co));
`ifdef PIPE_CSEL_ADDER_OVF_EN
        chk("stream_ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
    if (acc) begin
      q.push_back(model(ia, ib, ic, is));
      beats++;
    end
    hold = out_valid && !out_ready;
    hy = y;
    hc = cout;
  endtask

  initial begin
    logic acc;
    int sent, p0, cyc;
    vt[0]  = '{16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0};
    vt[1]  = '{16'hFFFF, 16'h0001, 1, 0, 16'h0001, 1, 0};
    vt[2]  = '{16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0};
    vt[3]  = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    vt[4]  = '{16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0};
    vt[5]  = '{16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0};
    vt[6]  = '{16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1};
    vt[7]  = '{16'h0007, 16'h0007, 0, 1, 16'h0000, 1, 0};
    vt[8]  = '{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0};
    vt[9]  = '{16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0};
    vt[10] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
    #1 rst_n = 0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

    foreach (vt[i]) begin
      @(negedge clk);
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
      in_valid = 1; out_ready = 1;
      #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 0;
      #1 chk("vec_lat1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1 chk("vec_lat2_valid", 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vt[i].y));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vt[i].co));
`ifdef PIPE_CSEL_ADDER_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
`endif
    end
    step(0, 0, 0, 0, 0, 1, acc);

    sent = 0;
    p0 = pops;
    for (int c = 0; c < 3; c++) begin
      step(sent < 4, vt[sent].a, vt[sent].b, vt[sent].cin, vt[sent].sub, 0, acc);
      if (acc) sent++;
    end
    chk("bp_accepted", 32'(sent), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    cyc = 0;
    while ((sent < 4 || q.size() != 0) && cyc < 20) begin
      step(sent < 4, vt[sent % 11].a, vt[sent % 11].b, vt[sent % 11].cin, vt[sent % 11].sub, 1, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("bp_sent", 32'(sent), 32'd4);
    chk("bp_emitted", 32'(pops - p0), 32'd4);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    step(1, 16'h1111, 16'h2222, 0, 0, 0, acc);
    step(1, 16'h3333, 16'h4444, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("rstfly_full", 32'(out_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rstfly_out_valid", 32'(out_valid), 32'd0);
    chk("rstfly_in_ready", 32'(in_ready), 32'd1);
    chk("rstfly_y", 32'(y), 32'd0);
    q.delete();
    hold = 0;
    @(negedge clk);
    rst_n = 1;
    #1 chk("rstfly_rel_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 0, 1, acc);
      chk("rstfly_no_stale", 32'(out_valid), 32'd0);
    end

    beats = 0;
    cyc = 0;
    while (beats < 10000 && cyc < 40000) begin
      step($urandom_range(99) < 70, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(99) < 70, acc);
      cyc++;
    end
    chk("rand_beats", 32'(beats >= 10000), 32'd1);
    cyc = 0;
    while (q.size() != 0 && cyc < 10) begin
      step(0, 0, 0, 0, 0, 1, acc);
      cyc++;
    end
    chk("rand_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
